// File: rtl/game_master_ctrl.sv
// Master-board (P1) Bingo game sequencer: opens games, orders selection/guess turns, settles the win.
// Optional GAME_LINK_TIMEOUT_EN adds a wait-state watchdog with a link_err pulse.
module game_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       start_game,
    input  logic [7:0] cur_number_BCD,
    input  logic       sel_done,
    input  logic       guess_done,
    input  logic       i_win,
    input  logic       inter_ready,
    input  logic       interboard_en,
    input  logic [2:0] interboard_msg_type,
    input  logic [4:0] interboard_number,
    output logic       transmit,
    output logic       ctrl_en,
    output logic [2:0] ctrl_msg_type,
    output logic [4:0] ctrl_number,
    output logic       clear_sel,
    output logic       start_sel,
    output logic       clear_guess,
    output logic       start_guess,
    output logic [3:0] game_state,
    output logic [1:0] result
`ifdef GAME_LINK_TIMEOUT_EN
    ,
    output logic       link_err
`endif
);

    localparam logic [2:0] MSG_STATE_TURN = 3'd1;
    localparam logic [2:0] MSG_SEL_NUM    = 3'd2;
    localparam logic [2:0] MSG_STATE_WIN  = 3'd3;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        SEND_OPEN     = 4'd1,
        P1_SEL        = 4'd2,
        SEND_SEL_END  = 4'd3,
        WAIT_P2_SEL   = 4'd4,
        P1_GUESS      = 4'd5,
        P1_CHECK_WIN  = 4'd6,
        SEND_NUM      = 4'd7,
        SEND_WIN      = 4'd8,
        WAIT_P2_GUESS = 4'd9,
        WAIT_UPDATE   = 4'd10,
        FIN           = 4'd11,
        SEND_CLOSE    = 4'd12
    } state_t;

    state_t     state, nxt;
    logic       sent, rx_turn, rx_sel, rx_win, timeout;
    logic [4:0] num_bin;

    // The received number is not needed on the master side.
    logic unused_rx;
    assign unused_rx = ^interboard_number;

    function automatic logic is_send(state_t s);
        return s == SEND_OPEN || s == SEND_SEL_END || s == SEND_NUM ||
               s == SEND_WIN  || s == SEND_CLOSE;
    endfunction

    assign game_state = state;
    assign num_bin    = 5'({4'd0, cur_number_BCD[7:4]} * 8'd10 + {4'd0, cur_number_BCD[3:0]});
    // ctrl_en is high only in the first cycle of a send, so ready then is ignored.
    assign sent       = transmit && !ctrl_en && inter_ready;
    assign rx_turn    = interboard_en && interboard_msg_type == MSG_STATE_TURN;
    assign rx_sel     = interboard_en && interboard_msg_type == MSG_SEL_NUM;
    assign rx_win     = interboard_en && interboard_msg_type == MSG_STATE_WIN;

`ifdef GAME_LINK_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        timed;
    assign timed   = state == WAIT_P2_SEL || state == WAIT_P2_GUESS || is_send(state);
    assign timeout = timed && to_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:          if (start_game) nxt = SEND_OPEN;
            SEND_OPEN:     if (sent) nxt = P1_SEL;
            P1_SEL:        if (sel_done) nxt = SEND_SEL_END;
            SEND_SEL_END:  if (sent) nxt = WAIT_P2_SEL;
            WAIT_P2_SEL:   if (rx_turn) nxt = P1_GUESS;
            P1_GUESS:      if (guess_done) nxt = P1_CHECK_WIN;
            P1_CHECK_WIN:  nxt = i_win ? SEND_WIN : SEND_NUM;
            SEND_NUM:      if (sent) nxt = WAIT_P2_GUESS;
            SEND_WIN:      if (sent) nxt = FIN;
            WAIT_P2_GUESS: if (rx_sel) nxt = WAIT_UPDATE;
                           else if (rx_win) nxt = FIN;
            WAIT_UPDATE:   if (guess_done) nxt = i_win ? SEND_WIN : P1_GUESS;
            FIN:           if (start_game) nxt = SEND_CLOSE;
            SEND_CLOSE:    if (sent) nxt = IDLE;
            default:       nxt = IDLE;
        endcase
        if (timeout) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state         <= IDLE;
            transmit      <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_msg_type <= 3'd0;
            ctrl_number   <= 5'd0;
            clear_sel     <= 1'b1;
            start_sel     <= 1'b0;
            clear_guess   <= 1'b0;
            start_guess   <= 1'b0;
            result        <= 2'b00;
`ifdef GAME_LINK_TIMEOUT_EN
            link_err      <= 1'b0;
            to_cnt        <= 32'd0;
`endif
        end else begin
            ctrl_en     <= 1'b0;
            start_sel   <= 1'b0;
            clear_guess <= 1'b0;
            if (state == P1_GUESS && guess_done)
                ctrl_number <= num_bin;
            if (state == WAIT_P2_GUESS && nxt == FIN)
                result <= 2'b10;
            if (nxt == SEND_WIN && state != SEND_WIN)
                result <= 2'b01;
            if (state == SEND_CLOSE && nxt == IDLE) begin
                clear_guess <= 1'b1;
                result      <= 2'b00;
            end
`ifdef GAME_LINK_TIMEOUT_EN
            link_err <= timeout;
            if (timeout) begin
                result      <= 2'b11;
                clear_guess <= 1'b1;
            end
            to_cnt <= (nxt != state || !timed) ? 32'd0 : to_cnt + 32'd1;
`endif
            state <= nxt;
            // Outputs are registered against the state being entered.
            if (nxt != state) begin
                ctrl_en     <= is_send(nxt);
                transmit    <= is_send(nxt);
                start_sel   <= nxt == P1_SEL;
                start_guess <= nxt == P1_GUESS || nxt == WAIT_UPDATE;
                clear_sel   <= nxt == IDLE;
                if (is_send(nxt))
                    ctrl_msg_type <= (nxt == SEND_NUM) ? MSG_SEL_NUM :
                                     (nxt == SEND_WIN) ? MSG_STATE_WIN : MSG_STATE_TURN;
            end else if (state == WAIT_UPDATE) begin
                start_guess <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_master_ctrl.sv
// Directed game sequences with randomized numbers, ready delays and stray messages for game_master_ctrl.
module tb_game_master_ctrl;

    localparam int T_TURN = 1, T_SEL = 2, T_WIN = 3;
    localparam int S_IDLE = 0, S_OPEN = 1, S_P1SEL = 2, S_SELEND = 3, S_WSEL = 4, S_GUESS = 5,
                   S_CHK = 6, S_NUM = 7, S_SWIN = 8, S_WGUESS = 9, S_WUPD = 10, S_FIN = 11, S_CLOSE = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, interboard_rst = 1'b0, start_game = 1'b0;
    logic [7:0] cur_number_BCD = 8'h00;
    logic sel_done = 1'b0, guess_done = 1'b0, i_win = 1'b0, inter_ready = 1'b0, interboard_en = 1'b0;
    logic [2:0] interboard_msg_type = 3'd0;
    logic [4:0] interboard_number = 5'd0;
    logic transmit, ctrl_en, clear_sel, start_sel, clear_guess, start_guess;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic [3:0] game_state;
    logic [1:0] result;

    game_master_ctrl dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .start_game(start_game),
        .cur_number_BCD(cur_number_BCD), .sel_done(sel_done), .guess_done(guess_done), .i_win(i_win),
        .inter_ready(inter_ready), .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
        .interboard_number(interboard_number), .transmit(transmit), .ctrl_en(ctrl_en),
        .ctrl_msg_type(ctrl_msg_type), .ctrl_number(ctrl_number), .clear_sel(clear_sel),
        .start_sel(start_sel), .clear_guess(clear_guess), .start_guess(start_guess),
        .game_state(game_state), .result(result)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal value of the two BCD digits, kept to 5 bits.
    function automatic int bcd_value(input logic [7:0] b);
        return ((int'(b[7:4]) * 10) + int'(b[3:0])) % 32;
    endfunction

    function automatic logic [7:0] rand_bcd();
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        return {hi, lo};
    endfunction

    task automatic send_phase(input string tag, input int st, input int typ, input int num, input int nxt);
        int w;
        chk({tag, ".en"}, ctrl_en, 1);
        chk({tag, ".tx"}, transmit, 1);
        chk({tag, ".st"}, game_state, st);
        chk({tag, ".type"}, ctrl_msg_type, typ);
        if (num >= 0) chk({tag, ".num"}, ctrl_number, num);
        inter_ready = 1'($urandom_range(0, 1));
        tick();
        chk({tag, ".hold"}, game_state, st);
        chk({tag, ".en1"}, ctrl_en, 0);
        w = $urandom_range(0, 3);
        repeat (w) begin
            inter_ready = 1'b0;
            tick();
            chk({tag, ".wait"}, game_state, st);
            chk({tag, ".txw"}, transmit, 1);
            chk({tag, ".typew"}, ctrl_msg_type, typ);
            if (num >= 0) chk({tag, ".numw"}, ctrl_number, num);
        end
        inter_ready = 1'b1;
        tick();
        inter_ready = 1'b0;
        chk({tag, ".exit"}, game_state, nxt);
    endtask

    task automatic rx(input int typ, input int num);
        interboard_en = 1'b1;
        interboard_msg_type = 3'(typ);
        interboard_number = 5'(num);
        tick();
        interboard_en = 1'b0;
    endtask

    task automatic open_to_guess();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        send_phase("open", S_OPEN, T_TURN, -1, S_P1SEL);
        chk("start_sel", start_sel, 1);
        rx(T_TURN, 0);
        chk("sel_hold", game_state, S_P1SEL);
        chk("start_sel_off", start_sel, 0);
        sel_done = 1'b1;
        tick();
        sel_done = 1'b0;
        send_phase("sel_end", S_SELEND, T_TURN, -1, S_WSEL);
        rx(T_SEL, $urandom_range(0, 31));
        chk("wsel_ignore", game_state, S_WSEL);
        rx(T_TURN, 0);
        chk("guess_entry", game_state, S_GUESS);
        chk("start_guess", start_guess, 1);
    endtask

    task automatic guess_send(input logic [7:0] bcd, input logic win);
        cur_number_BCD = bcd;
        i_win = ~win;
        tick();
        chk("guess_held", start_guess, 1);
        chk("guess_wait", game_state, S_GUESS);
        guess_done = 1'b1;
        tick();
        guess_done = 1'b0;
        i_win = win;
        chk("check_win", game_state, S_CHK);
        cur_number_BCD = 8'h05;
        tick();
        i_win = 1'b0;
        if (win) begin
            chk("win_result", result, 1);
            send_phase("send_win", S_SWIN, T_WIN, -1, S_FIN);
        end else begin
            send_phase("send_num", S_NUM, T_SEL, bcd_value(bcd), S_WGUESS);
        end
    endtask

    task automatic close_game();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        send_phase("close", S_CLOSE, T_TURN, -1, S_IDLE);
        chk("close_clr_guess", clear_guess, 1);
        chk("close_result", result, 0);
        chk("close_clr_sel", clear_sel, 1);
        tick();
        chk("clr_guess_pulse", clear_guess, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_state", game_state, S_IDLE);
        chk("rst_clear_sel", clear_sel, 1);
        chk("rst_result", result, 0);
        chk("rst_ctrl_en", ctrl_en, 0);
        chk("rst_transmit", transmit, 0);
        rst = 1'b0;
        tick();
        chk("idle_stay", game_state, S_IDLE);

        // Game 1: P1 passes a number, P2 answers, then P1 wins after an update.
        open_to_guess();
        guess_send(8'h23, 1'b0);
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        chk("start_ignored", game_state, S_WGUESS);
        rx(T_TURN, 0);
        chk("wguess_ignore", game_state, S_WGUESS);
        rx(T_SEL, 7);
        chk("upd_entry", game_state, S_WUPD);
        chk("upd_start_guess", start_guess, 1);
        i_win = 1'b1;
        tick();
        chk("upd_pulse", start_guess, 0);
        chk("upd_wait", game_state, S_WUPD);
        i_win = 1'b0;
        guess_done = 1'b1;
        tick();
        guess_done = 1'b0;
        chk("upd_to_guess", game_state, S_GUESS);
        guess_send(8'h99, 1'b0);
        guess_send_rand_loop: begin
            rx(T_SEL, $urandom_range(0, 31));
            chk("upd2_entry", game_state, S_WUPD);
            i_win = 1'b1;
            guess_done = 1'b1;
            tick();
            guess_done = 1'b0;
            i_win = 1'b0;
            chk("upd_win_result", result, 1);
            send_phase("upd_win", S_SWIN, T_WIN, -1, S_FIN);
            chk("fin_result", result, 1);
        end
        close_game();

        // Game 2: P2 declares the win.
        open_to_guess();
        guess_send(rand_bcd(), 1'b0);
        rx(T_WIN, 0);
        chk("p2_win_state", game_state, S_FIN);
        chk("p2_win_result", result, 2);
        close_game();

        // Game 3: P1 wins directly from its own guess, random numbers along the way.
        open_to_guess();
        for (int i = 0; i < 3; i++) begin
            guess_send(rand_bcd(), 1'b0);
            rx(T_SEL, $urandom_range(0, 31));
            guess_done = 1'b1;
            tick();
            guess_done = 1'b0;
            chk("loop_back", game_state, S_GUESS);
        end
        guess_send(rand_bcd(), 1'b1);
        close_game();

        // Game 4: link reset while a number is being sent.
        open_to_guess();
        guess_done = 1'b1;
        tick();
        guess_done = 1'b0;
        tick();
        chk("pre_rst_num", game_state, S_NUM);
        interboard_rst = 1'b1;
        tick();
        interboard_rst = 1'b0;
        chk("lrst_state", game_state, S_IDLE);
        chk("lrst_tx", transmit, 0);
        chk("lrst_clear_sel", clear_sel, 1);
        for (int i = 0; i < 3; i++) begin
            inter_ready = 1'b1;
            tick();
            chk("lrst_no_en", ctrl_en, 0);
            chk("lrst_idle", game_state, S_IDLE);
        end
        inter_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_master_ctrl.md
Name: game_master_ctrl

Overview:
- Master-board (P1) Bingo game sequencer; the initiating end of the interboard game protocol that the slave game controller answers.
- Opens each game, orders selection and guess turns, and declares or accepts the win.
- Drives the interboard transmitter through ctrl_en, ctrl_msg_type, ctrl_number and transmit, and consumes received messages.
- Sequences the local selection, guess and win-check blocks through strobe and handshake ports.

Parameters:
- TIMEOUT_CYCLES, 50_000_000: wait-state watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- interboard_rst  in  1  synchronous active-high reset from the link; same effect as rst
- start_game  in  1  one-cycle pulse; starts a game from IDLE
- cur_number_BCD  in  8  two-digit BCD number currently selected by the player
- sel_done  in  1  local selection-block handshake: 25 numbers placed
- guess_done  in  1  local guess-block handshake: guess marked
- i_win  in  1  local board has at least the winning line count
- inter_ready  in  1  transmitter idle / previous message sent
- interboard_en  in  1  received-message valid pulse
- interboard_msg_type  in  3  received message type (message_macro codes)
- interboard_number  in  5  received number (binary)
- transmit  out  1  transmitter owned by this block
- ctrl_en  out  1  one-cycle send request
- ctrl_msg_type  out  3  message type to send
- ctrl_number  out  5  binary number to send
- clear_sel, start_sel, clear_guess, start_guess  out  1 each  local block strobes
- game_state  out  4  current state encoding
- result  out  2  00 none, 01 P1 won, 10 P2 won

Behaviour:
- Clock and reset: one clock clk. rst and interboard_rst are synchronous and active-high, sampled on the posedge of clk.
- Reset: state IDLE; result 00; all outputs 0 except clear_sel=1 (IDLE).
- States and transitions:
  - IDLE: on start_game -> SEND_OPEN.
  - SEND_OPEN: send STATE_TURN; on inter_ready after the send -> P1_SEL.
  - P1_SEL: start_sel pulses 1 cycle on entry; on sel_done -> SEND_SEL_END.
  - SEND_SEL_END: send STATE_TURN; on ready -> WAIT_P2_SEL.
  - WAIT_P2_SEL: on rx STATE_TURN -> P1_GUESS.
  - P1_GUESS: start_guess held; on guess_done -> P1_CHECK_WIN.
  - P1_CHECK_WIN: 1 cycle; i_win -> SEND_WIN, else -> SEND_NUM.
  - SEND_NUM: send SEL_NUM with ctrl_number; on ready -> WAIT_P2_GUESS.
  - SEND_WIN: send STATE_WIN; result=01; on ready -> FIN.
  - WAIT_P2_GUESS: rx SEL_NUM -> WAIT_UPDATE (start_guess 1 cycle); rx STATE_WIN -> FIN with result=10.
  - WAIT_UPDATE: on guess_done -> i_win ? SEND_WIN : P1_GUESS.
  - FIN: on start_game -> SEND_CLOSE.
  - SEND_CLOSE: send STATE_TURN (resets the slave); on ready -> IDLE; clear_guess pulses on exit; result -> 00.
- Send handshake:
  - ctrl_en=1 for exactly the first cycle of each SEND_* state.
  - transmit=1 throughout the SEND_* state.
  - ctrl_msg_type and ctrl_number are held stable for the whole state.
  - Exit requires inter_ready=1 on a cycle after the ctrl_en cycle; inter_ready during the ctrl_en cycle is ignored.
- ctrl_number: 10*cur_number_BCD[7:4]+cur_number_BCD[3:0], truncated to 5 bits. It is latched on entry to P1_CHECK_WIN, so later changes to cur_number_BCD do not alter the sent value.
- clear_sel=1 in IDLE only. start_game outside IDLE/FIN is ignored.
- Received messages with an unexpected type in the current state are ignored. interboard_en outside WAIT_* states is ignored.
- i_win is sampled only in P1_CHECK_WIN and WAIT_UPDATE.
- rst or interboard_rst mid-game -> IDLE next cycle; an outstanding send is abandoned and ctrl_en is not reissued.

Optional Feature:
- GAME_LINK_TIMEOUT_EN defined: a counter runs in WAIT_P2_SEL, WAIT_P2_GUESS and every SEND_* state, and clears on every state change.
  - On reaching TIMEOUT_CYCLES: -> IDLE, result=11, an output link_err pulses 1 cycle, and clear_guess pulses.
- Undefined: no counter, no link_err port, waits are unbounded, and result=11 is never produced.

Test Plan:
- Reset then start_game -> SEND_OPEN, ctrl_en 1 cycle with type STATE_TURN; inter_ready -> P1_SEL and start_sel pulse.
- sel_done -> STATE_TURN sent; rx STATE_TURN -> P1_GUESS.
- cur_number_BCD=8'h23, guess_done, i_win=0 -> SEND_NUM, ctrl_number=23, type SEL_NUM.
- cur_number_BCD changed to 8'h05 during SEND_NUM -> ctrl_number stays 23.
- In WAIT_P2_GUESS: rx SEL_NUM number 7, then guess_done with i_win=1 -> STATE_WIN sent, result=01, FIN.
- In WAIT_P2_GUESS: rx STATE_WIN -> FIN, result=10.
- From FIN: start_game then inter_ready -> IDLE, clear_guess pulse, result=00.
- interboard_rst asserted during SEND_NUM -> IDLE next cycle with no further ctrl_en.
- With GAME_LINK_TIMEOUT_EN and TIMEOUT_CYCLES=16: 16 idle cycles in WAIT_P2_SEL -> IDLE, result=11, link_err pulse.
